// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch stage: program counter, single-outstanding imem requests, redirect and squash
module pc_fetch_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exec_valid,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_out,
    input  logic            instr_ready,
    output logic            misalign_err
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            squash_q, squash_d;
    logic            misalign_q, misalign_d;
    logic            req_en_q, req_en_d;

    logic            redirect;
    logic            req_fire;
    logic            rsp_keep;
    logic [XLEN-1:0] target_aligned;
    logic            unused_target_bit0;

    assign redirect           = exec_valid & br_taken;
    assign req_fire           = (state_q == S_REQ) & req_en_q & imem_req_ready;
    assign rsp_keep           = (state_q == S_WAIT) & imem_rsp_valid & ~squash_q & ~redirect;
    assign target_aligned     = {br_target[XLEN-1:2], 2'b00};
    assign unused_target_bit0 = br_target[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // req_en_q keeps imem_req_valid low for the first cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_out_q   <= '0;
            squash_q   <= 1'b0;
            misalign_q <= 1'b0;
            req_en_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            squash_q   <= squash_d;
            misalign_q <= misalign_d;
            req_en_q   <= req_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   if (req_fire) state_d = S_WAIT;
            S_WAIT:  if (imem_rsp_valid) state_d = (squash_q || redirect) ? S_REQ : S_HOLD;
            S_HOLD:  if (redirect || instr_ready) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        squash_d   = squash_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        misalign_d = redirect & br_target[1];
        req_en_d   = 1'b1;

        if (redirect) begin
            pc_d = target_aligned;
        end else if ((state_q == S_HOLD) && instr_ready) begin
            pc_d = pc_q + XLEN'(4);
        end

        // a redirect while a request is outstanding must discard that response
        if (state_q == S_REQ) begin
            if (req_fire && redirect) squash_d = 1'b1;
        end else if (state_q == S_WAIT) begin
            if (imem_rsp_valid) squash_d = 1'b0;
            else if (redirect) squash_d = 1'b1;
        end

        if (rsp_keep) begin
            instr_d  = imem_rsp_data;
            pc_out_d = pc_q;
        end
    end

    always_comb begin
        imem_req_valid = (state_q == S_REQ) & req_en_q;
        imem_req_addr  = pc_q;
        instr_valid    = (state_q == S_HOLD);
        instr          = instr_q;
        pc_out         = pc_out_q;
        misalign_err   = misalign_q;
    end

endmodule
